// File: rtl/gomoku_board_ctrl_pkg.sv
// Shared types and constants for the gomoku board controller and its line scanner.
package gomoku_board_ctrl_pkg;

    localparam int N_DEF       = 15;
    localparam int WIN_LEN_DEF = 5;

    typedef logic [1:0] cell_t;
    localparam cell_t EMPTY = 2'b00;
    localparam cell_t BLACK = 2'b01;
    localparam cell_t WHITE = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OVER = 2'd2} state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } dir_step_t;

    // d = 0..3 : horizontal, vertical, diagonal, anti-diagonal
    function automatic dir_step_t dir_step(input logic [1:0] d);
        dir_step_t s;
        case (d)
            2'd0:    begin s.dx = 2'b01; s.dy = 2'b00; end
            2'd1:    begin s.dx = 2'b00; s.dy = 2'b01; end
            2'd2:    begin s.dx = 2'b01; s.dy = 2'b01; end
            default: begin s.dx = 2'b01; s.dy = 2'b11; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gomoku_line_scanner.sv
// Walks all four line directions through the last-placed stone, one board probe per
// cycle, and reports whether a run of WIN_LEN of the placed colour exists.
module gomoku_line_scanner
    import gomoku_board_ctrl_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          start,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    input  cell_t         colour,
    output logic [CW-1:0] probe_x,
    output logic [CW-1:0] probe_y,
    output logic          probe_ok,
    input  cell_t         probe_cell,
    output logic          done,
    output logic          win
);

    localparam int SW = (WIN_LEN > 2) ? $clog2(WIN_LEN - 1) : 1;
    localparam int RW = $clog2(WIN_LEN + 1);
    localparam logic signed [CW:0] NS   = (CW+1)'(N);
    localparam logic signed [CW:0] ZERO = '0;

    function automatic logic signed [CW:0] sext(input logic signed [1:0] v);
        return $signed({{(CW-1){v[1]}}, v});
    endfunction

    logic                 active;
    logic [1:0]           dir;
    logic                 side;
    logic [SW-1:0]        step;
    logic [RW-1:0]        run;
    logic                 blocked;
    logic signed [CW:0]   cx, cy, ox, oy;
    cell_t                col;

    dir_step_t            st_cur, st_nxt, st_first;
    logic signed [CW:0]   dx, dy, ndx, ndy;
    logic                 hit, last_step;

    always_comb begin
        st_cur   = dir_step(dir);
        st_nxt   = dir_step(dir + 2'd1);
        st_first = dir_step(2'd0);
        dx  = sext(st_cur.dx);
        dy  = sext(st_cur.dy);
        ndx = sext(st_nxt.dx);
        ndy = sext(st_nxt.dy);
    end

    // Coordinates may leave the board (or even wrap) once a side is blocked; the bounds
    // check gates every probe so nothing outside the grid is ever indexed.
    assign probe_ok  = active && (cx >= ZERO) && (cx < NS) && (cy >= ZERO) && (cy < NS);
    assign probe_x   = cx[CW-1:0];
    assign probe_y   = cy[CW-1:0];
    assign hit       = probe_ok && !blocked && (probe_cell == col);
    assign last_step = (step == SW'(WIN_LEN - 2));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            active  <= 1'b0;
            done    <= 1'b0;
            win     <= 1'b0;
            dir     <= '0;
            side    <= 1'b0;
            step    <= '0;
            run     <= '0;
            blocked <= 1'b0;
            cx      <= '0;
            cy      <= '0;
            ox      <= '0;
            oy      <= '0;
            col     <= EMPTY;
        end else if (start) begin
            active  <= 1'b1;
            done    <= 1'b0;
            win     <= 1'b0;
            dir     <= '0;
            side    <= 1'b0;
            step    <= '0;
            run     <= RW'(1);
            blocked <= 1'b0;
            ox      <= $signed({1'b0, px});
            oy      <= $signed({1'b0, py});
            cx      <= $signed({1'b0, px}) + sext(st_first.dx);
            cy      <= $signed({1'b0, py}) + sext(st_first.dy);
            col     <= colour;
        end else if (active) begin
            // Every side takes the full WIN_LEN-1 cycles so the scan length is fixed.
            if (hit)  run     <= run + RW'(1);
            if (!hit) blocked <= 1'b1;
            if (hit && run == RW'(WIN_LEN - 1)) begin
                active <= 1'b0;
                done   <= 1'b1;
                win    <= 1'b1;
            end else if (last_step) begin
                step    <= '0;
                blocked <= 1'b0;
                if (!side) begin
                    side <= 1'b1;
                    cx   <= ox - dx;
                    cy   <= oy - dy;
                end else begin
                    side <= 1'b0;
                    run  <= RW'(1);
                    dir  <= dir + 2'd1;
                    cx   <= ox + ndx;
                    cy   <= oy + ndy;
                    if (dir == 2'd3) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            end else begin
                step <= step + SW'(1);
                cx   <= side ? cx - dx : cx + dx;
                cy   <= side ? cy - dy : cy + dy;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Gomoku game-state controller: board storage, cursor, turn, placement and win/draw
// detection, plus a registered cell read port for the renderer.
module gomoku_board_ctrl
    import gomoku_board_ctrl_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_place,
    input  logic          new_game,
    input  logic [CW-1:0] rd_x,
    input  logic [CW-1:0] rd_y,
    output logic [1:0]    rd_cell,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic          turn,
    output logic          busy,
    output logic          game_over,
    output logic [1:0]    winner
);

    localparam int MCW = $clog2(N*N + 1);
    localparam logic [MCW-1:0] FULL = MCW'(N*N);
    localparam logic [CW-1:0]  MID  = CW'(N/2);
    localparam logic [CW-1:0]  MAXC = CW'(N-1);
    localparam logic [CW:0]    NB   = (CW+1)'(N);

    state_t         state, state_nxt;
    cell_t          board [N][N];
    logic [MCW-1:0] move_cnt;
    logic           clr;
    cell_t          cur_cell, place_col, probe_cell;
    logic           place_ok, move_en, turn_flip;
    logic [CW-1:0]  nx, ny;
    logic [CW-1:0]  probe_x, probe_y;
    logic           probe_ok, scan_done, scan_win;

    assign clr       = rst || new_game;
    assign cur_cell  = board[cursor_y][cursor_x];
    assign place_col = turn ? WHITE : BLACK;
    assign busy      = (state == SCAN);
    assign game_over = (state == OVER);

    always_comb begin
        state_nxt = state;
        place_ok  = 1'b0;
        move_en   = 1'b0;
        turn_flip = 1'b0;
        case (state)
            IDLE: begin
                // A place pulse swallows any simultaneous cursor moves.
                if (btn_place) begin
                    if (cur_cell == EMPTY) begin
                        place_ok  = 1'b1;
                        state_nxt = SCAN;
                    end
                end else begin
                    move_en = 1'b1;
                end
            end
            SCAN: begin
                if (scan_done) begin
                    if (scan_win || move_cnt == FULL) begin
                        state_nxt = OVER;
                    end else begin
                        state_nxt = IDLE;
                        turn_flip = 1'b1;
                    end
                end
            end
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nx = cursor_x;
        ny = cursor_y;
        if (move_en) begin
            if (btn_left && !btn_right && cursor_x != '0)       nx = cursor_x - CW'(1);
            else if (btn_right && !btn_left && cursor_x != MAXC) nx = cursor_x + CW'(1);
            if (btn_up && !btn_down && cursor_y != '0)          ny = cursor_y - CW'(1);
            else if (btn_down && !btn_up && cursor_y != MAXC)    ny = cursor_y + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cursor_x <= MID;
            cursor_y <= MID;
            turn     <= 1'b0;
            winner   <= EMPTY;
            move_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cursor_x <= nx;
            cursor_y <= ny;
            if (turn_flip) turn <= ~turn;
            if (place_ok)  move_cnt <= move_cnt + MCW'(1);
            if (state == SCAN && scan_done && scan_win) winner <= place_col;
        end
    end

    // Board: one write port (placement) and two independent read paths.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    board[y][x] <= EMPTY;
        end else if (place_ok) begin
            board[cursor_y][cursor_x] <= place_col;
        end
    end

    always_ff @(posedge clk) begin
        if (clr)
            rd_cell <= EMPTY;
        else if ({1'b0, rd_x} < NB && {1'b0, rd_y} < NB)
            rd_cell <= board[rd_y][rd_x];
        else
            rd_cell <= EMPTY;
    end

    assign probe_cell = probe_ok ? board[probe_y][probe_x] : EMPTY;

    gomoku_line_scanner #(.N(N), .WIN_LEN(WIN_LEN), .CW(CW)) u_scan (
        .clk        (clk),
        .rst        (rst),
        .clr        (new_game),
        .start      (place_ok),
        .px         (cursor_x),
        .py         (cursor_y),
        .colour     (place_col),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_ok   (probe_ok),
        .probe_cell (probe_cell),
        .done       (scan_done),
        .win        (scan_win)
    );

endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Directed bench for gomoku_board_ctrl: cursor, placement, scans, wins, draw, read port.
module tb_gomoku_board_ctrl;
    import gomoku_board_ctrl_pkg::*;

    localparam int N  = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_up, btn_down, btn_left, btn_right, btn_place, new_game;
    logic [CW-1:0] rd_x, rd_y;
    logic [1:0]    rd_cell;
    logic [CW-1:0] cursor_x, cursor_y;
    logic          turn, busy, game_over;
    logic [1:0]    winner;

    always #5 clk = ~clk;

    gomoku_board_ctrl #(.N(N), .WIN_LEN(5), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .new_game(new_game),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .turn(turn), .busy(busy), .game_over(game_over), .winner(winner)
    );

    int         tests = 0;
    int         fails = 0;
    int         mx, my;
    int         ncyc;
    logic [1:0] exp_q[$];
    int         bx[$], by[$], wx[$], wy[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic query(input int x, input int y, input logic [1:0] e);
        rd_x = CW'(x);
        rd_y = CW'(y);
        exp_q.push_back(e);
        @(negedge clk);
        check("rd_cell", {6'd0, rd_cell}, {6'd0, exp_q.pop_front()});
    endtask

    task automatic goto(input int x, input int y);
        int guard = 0;
        while ((mx != x || my != y) && guard < 64) begin
            btn_left  = (x < mx);
            btn_right = (x > mx);
            btn_up    = (y < my);
            btn_down  = (y > my);
            @(negedge clk);
            if (x < mx) mx--; else if (x > mx) mx++;
            if (y < my) my--; else if (y > my) my++;
            btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
            guard++;
        end
    endtask

    task automatic place_wait(output int n);
        btn_place = 1;
        @(negedge clk);
        btn_place = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic play(input int x, input int y);
        int n;
        goto(x, y);
        place_wait(n);
        check("scan_bound", {7'd0, (n > 0 && n < 100)}, 8'd1);
    endtask

    task automatic restart();
        new_game = 1;
        @(negedge clk);
        new_game = 0;
        mx = 7;
        my = 7;
    endtask

    initial begin
        rst = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_place = 0; new_game = 0; rd_x = 0; rd_y = 0;
        mx = 7; my = 7;
        repeat (3) @(negedge clk);
        rst = 0;

        // reset state
        check("rst_cx", {4'd0, cursor_x}, 8'd7);
        check("rst_cy", {4'd0, cursor_y}, 8'd7);
        check("rst_turn", {7'd0, turn}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_over", {7'd0, game_over}, 8'd0);
        check("rst_winner", {6'd0, winner}, 8'd0);
        check("rst_rdcell", {6'd0, rd_cell}, 8'd0);

        // left x9 saturates at 0
        for (int i = 0; i < 9; i++) begin
            btn_left = 1;
            @(negedge clk);
            btn_left = 0;
            if (mx > 0) mx--;
            if (i == 6) check("cx_after7", {4'd0, cursor_x}, 8'(mx));
        end
        check("cx_sat0", {4'd0, cursor_x}, 8'(mx));
        btn_up = 1; btn_down = 1;
        @(negedge clk);
        btn_up = 0; btn_down = 0;
        check("cy_updown", {4'd0, cursor_y}, 8'd7);
        btn_right = 1; btn_down = 1;
        @(negedge clk);
        btn_right = 0; btn_down = 0;
        mx = 1; my = 8;
        check("xy_both_x", {4'd0, cursor_x}, 8'd1);
        check("xy_both_y", {4'd0, cursor_y}, 8'd8);
        goto(14, 14);
        btn_right = 1; btn_down = 1;
        @(negedge clk);
        btn_right = 0; btn_down = 0;
        check("sat_hi_x", {4'd0, cursor_x}, 8'd14);
        check("sat_hi_y", {4'd0, cursor_y}, 8'd14);

        // first placement: full 33-cycle scan, no run
        goto(7, 7);
        place_wait(ncyc);
        check("busy_len", 8'(ncyc), 8'd33);
        check("turn_white", {7'd0, turn}, 8'd1);
        check("no_over", {7'd0, game_over}, 8'd0);
        query(7, 7, BLACK);

        // occupied cell ignored
        btn_place = 1;
        @(negedge clk);
        btn_place = 0;
        check("occ_busy", {7'd0, busy}, 8'd0);
        check("occ_turn", {7'd0, turn}, 8'd1);
        query(7, 7, BLACK);

        // horizontal win for black
        restart();
        check("ng_turn", {7'd0, turn}, 8'd0);
        query(7, 7, EMPTY);
        play(3, 4); play(0, 12); play(4, 4); play(2, 12);
        play(5, 4); play(4, 12); play(6, 4); play(6, 12);
        play(7, 4);
        check("h_over", {7'd0, game_over}, 8'd1);
        check("h_winner", {6'd0, winner}, {6'd0, BLACK});
        check("h_turn", {7'd0, turn}, 8'd0);
        btn_right = 1; btn_place = 1;
        @(negedge clk);
        btn_right = 0; btn_place = 0;
        @(negedge clk);
        check("over_cx", {4'd0, cursor_x}, 8'd7);
        check("over_busy", {7'd0, busy}, 8'd0);
        query(8, 4, EMPTY);
        query(7, 4, BLACK);

        // anti-diagonal win for white
        restart();
        play(0, 0); play(10, 2); play(2, 0); play(9, 3);
        play(4, 0); play(8, 4); play(6, 0); play(7, 5);
        play(8, 0); play(6, 6);
        check("ad_over", {7'd0, game_over}, 8'd1);
        check("ad_winner", {6'd0, winner}, {6'd0, WHITE});
        check("ad_turn", {7'd0, turn}, 8'd1);

        // run of 4 against the x=0 edge
        restart();
        play(1, 5); play(1, 9); play(2, 5); play(3, 9);
        play(3, 5); play(5, 9);
        goto(0, 5);
        place_wait(ncyc);
        check("edge_len", 8'(ncyc), 8'd33);
        check("edge_over", {7'd0, game_over}, 8'd0);
        check("edge_turn", {7'd0, turn}, 8'd1);
        query(15, 5, EMPTY);
        query(0, 15, EMPTY);
        query(0, 5, BLACK);

        // new_game aborts a running scan
        goto(10, 10);
        btn_place = 1;
        @(negedge clk);
        btn_place = 0;
        repeat (3) @(negedge clk);
        check("mid_busy", {7'd0, busy}, 8'd1);
        restart();
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_turn", {7'd0, turn}, 8'd0);
        check("abort_cx", {4'd0, cursor_x}, 8'd7);
        check("abort_cy", {4'd0, cursor_y}, 8'd7);
        check("abort_over", {7'd0, game_over}, 8'd0);
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                query(x, y, EMPTY);

        // fill the board without any five: colour by (x+2y) mod 4
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (((x + 2*y) % 4) < 2) begin bx.push_back(x); by.push_back(y); end
                else begin wx.push_back(x); wy.push_back(y); end
        check("black_cnt", 8'(bx.size()), 8'd113);
        for (int i = 0; i < 113; i++) begin
            if (i == 112) check("pre_draw_over", {7'd0, game_over}, 8'd0);
            play(bx[i], by[i]);
            if (i < 112) play(wx[i], wy[i]);
        end
        check("draw_over", {7'd0, game_over}, 8'd1);
        check("draw_winner", {6'd0, winner}, 8'd0);
        check("draw_busy", {7'd0, busy}, 8'd0);
        query(0, 0, BLACK);
        query(2, 0, WHITE);
        query(14, 14, WHITE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gomoku_board_ctrl.md
Name: gomoku_board_ctrl

Overview:
Game-state controller for the 15x15 five-in-a-row board shown on the VGA display. It owns the board cell storage, the cursor and turn alternation. It accepts debounced one-cycle button pulses, commits stones and runs a sequential win/draw scan after each placement. The pixel renderer queries it through a registered cell read port to colour stones and the cursor over the grid.

Parameters:
N, 15, board dimension (cells per side); coordinates 0..N-1
WIN_LEN, 5, stones in a line required to win
CW, 4, coordinate width, with 2^CW >= N

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
btn_up  in  1  one-cycle pulse: cursor_y - 1
btn_down  in  1  one-cycle pulse: cursor_y + 1
btn_left  in  1  one-cycle pulse: cursor_x - 1
btn_right  in  1  one-cycle pulse: cursor_x + 1
btn_place  in  1  one-cycle pulse: place stone at cursor
new_game  in  1  one-cycle pulse: clear board, restart
rd_x  in  CW  renderer query column
rd_y  in  CW  renderer query row
rd_cell  out  2  cell at (rd_x,rd_y), 1-cycle latency; 00 empty, 01 black, 10 white
cursor_x  out  CW  cursor column
cursor_y  out  CW  cursor row
turn  out  1  0 = black to move, 1 = white to move
busy  out  1  high while the scan runs; buttons are ignored
game_over  out  1  set on a win or a draw
winner  out  2  01 black, 10 white, 00 draw or none

Behaviour:
- Reset and new_game: all cells 00; cursor = (N/2, N/2) = (7,7); turn = 0; busy = 0; game_over = 0; winner = 00; move count = 0; rd_cell = 00. State goes to IDLE. rst and new_game act identically and abort any scan in progress. rst dominates all other inputs.
- State IDLE:
  - Cursor moves saturate at 0 and N-1; there is no wrap.
  - Up and down in the same cycle: y is unchanged. Left and right in the same cycle: x is unchanged. x and y moves in the same cycle both apply.
  - btn_place on an empty cell: the cell is written with (turn ? 10 : 01) on that edge. Move count increments. The next state is SCAN, with busy = 1 from the next cycle.
  - btn_place on an occupied cell is ignored: no state change and no turn change.
  - btn_place in the same cycle as any move: place wins, and the moves are dropped.
- State SCAN:
  - Scans directions d = 0..3 in order: horizontal (1,0), vertical (0,1), diagonal (1,1), anti-diagonal (1,-1).
  - For each direction, a run count starts at 1. Walk the + side one cell per cycle, up to WIN_LEN-1 steps, while the cell is in bounds and equal to the placed colour. Then walk the - side the same way.
  - As soon as the count reaches WIN_LEN, go to OVER. Record winner = placed colour.
  - After all 4 directions with no win: if move count == N*N, go to OVER with winner = 00 (draw). Otherwise turn toggles, busy drops and the next state is IDLE.
  - Worst-case scan is 4 x 2 x (WIN_LEN-1) = 32 cycles, plus 1 cycle for the decision.
- State OVER: game_over = 1 and busy = 0. All buttons except new_game are ignored.
- Buttons arriving while busy = 1 are dropped, not queued.
- Read port:
  - rd_cell is registered from (rd_x, rd_y) every cycle, regardless of state.
  - A write at edge t is visible to a query presented at edge t+1.
  - An out-of-range query (rd_x or rd_y >= N) returns 00.
  - The read port never stalls and has no arbitration with writes, because storage is a register array with one write port and one independent read port.
- Arithmetic:
  - Scan coordinates are held as CW+1-bit signed values. Bounds are checked before indexing.
  - Move count is ceil(log2(N*N+1)) bits wide.

Decomposition:
- Shared package holds:
  - cell encodings: EMPTY = 00, BLACK = 01, WHITE = 10
  - the state enum: IDLE, SCAN, OVER
  - the direction step table (dx, dy per d)
  - defaults for N and WIN_LEN
- One sub-module, gomoku_line_scanner, is natural. It takes the placed coordinate and colour plus a board read port, runs the direction/side/step counters and reports done, win.
- Board storage and cursor logic stay in the top level.

Test Plan:
- Reset, then btn_left x9 -> cursor_x reaches 0 after 7 pulses and stays 0. Then btn_up and btn_down in the same cycle -> cursor_y stays 7.
- Place at (7,7), then query rd_x=7, rd_y=7 -> rd_cell = 01 one cycle later. turn = 1 after busy falls. busy is high for exactly 33 cycles, with no run found.
- Place again at (7,7) as white -> ignored: cell stays 01, turn stays 1, busy stays 0.
- Black stones at (3..6,4) and white elsewhere, then black places (7,4) -> game_over = 1, winner = 01. Also check the anti-diagonal by building white (10,2),(9,3),(8,4),(7,5) and completing with (6,6) -> winner = 10.
- A run of 4 bounded by the board edge at x=0 -> no win, and no out-of-bounds index. rd_x = 15 -> rd_cell = 00.
- Assert new_game mid-SCAN -> next cycle busy = 0, every cell reads 00, cursor = (7,7), turn = 0. Fill all 225 cells with no five in a row -> winner = 00, game_over = 1.
